// File: rtl/rupt_priority.sv
// Interrupt request latch and priority encoder for the AGC control section.
// Latches request pulses, requests a RUPT sequence at NISQ, and tracks interrupt-in-progress.
module rupt_priority #(
    parameter logic [11:0] RUPT_BASE   = 12'o4000,
    parameter int unsigned RUPT_STRIDE = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [9:0]  rupt_req,
    input  logic        gojam,
    input  logic        nisq,
    input  logic        inhint,
    input  logic        ovnhrp,
    input  logic        ext,
    input  logic        resume,
    output logic        ruptor_n,
    output logic        krpt,
    output logic        iip,
    output logic [3:0]  rupt_index,
    output logic [11:0] rupt_addr,
    output logic [9:0]  pending
);

    localparam int unsigned NSRC = 10;
    localparam int unsigned IW   = 4;
    localparam int unsigned AW   = 12;

    logic [IW-1:0]   sel;
    logic [NSRC-1:0] sel_mask;
    logic [IW-1:0]   vec_idx;
    logic [AW-1:0]   vec_addr;
    logic            any;
    logic            accept;

    // Lowest-numbered pending source wins.
    always_comb begin
        sel      = '0;
        sel_mask = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel      = IW'(i);
                sel_mask = NSRC'(1) << i;
            end
        end
    end

    assign any      = |pending;
    assign ruptor_n = ~(any & ~iip & ~inhint & ~ovnhrp & ~ext);
    assign accept   = nisq & ~ruptor_n;
    assign vec_idx  = sel + IW'(1);
    assign vec_addr = RUPT_BASE + AW'(RUPT_STRIDE * vec_idx);

    // A request arriving on its own acceptance edge re-sets the latch so it is not lost.
    always_ff @(posedge clock) begin
        if (!rst_n || gojam) begin
            pending    <= '0;
            iip        <= 1'b0;
            krpt       <= 1'b0;
            rupt_index <= '0;
            rupt_addr  <= RUPT_BASE;
        end else begin
            krpt    <= accept;
            pending <= (pending & ~(accept ? sel_mask : NSRC'(0))) | rupt_req;
            if (accept) begin
                iip        <= 1'b1;
                rupt_index <= vec_idx;
                rupt_addr  <= vec_addr;
            end else if (resume && iip) begin
                iip        <= 1'b0;
                rupt_index <= '0;
                rupt_addr  <= RUPT_BASE;
            end
        end
    end

endmodule

// File: tb/tb_rupt_priority.sv
// Bench for rupt_priority: directed scenarios plus random traffic against a behavioural model.
module tb_rupt_priority;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rupt_req = '0;
    logic        gojam = 1'b0, nisq = 1'b0, inhint = 1'b0, ovnhrp = 1'b0, ext = 1'b0, resume = 1'b0;
    logic        ruptor_n, krpt, iip;
    logic [3:0]  rupt_index;
    logic [11:0] rupt_addr;
    logic [9:0]  pending;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_pend [10];
    bit m_iip;
    bit m_krpt;
    int m_idx;
    bit m_valid;

    rupt_priority dut (
        .clock(clock), .rst_n(rst_n), .rupt_req(rupt_req), .gojam(gojam), .nisq(nisq),
        .inhint(inhint), .ovnhrp(ovnhrp), .ext(ext), .resume(resume),
        .ruptor_n(ruptor_n), .krpt(krpt), .iip(iip), .rupt_index(rupt_index),
        .rupt_addr(rupt_addr), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_pending();
        logic [9:0] v = '0;
        for (int i = 0; i < 10; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: drive inputs, check the combinational request, advance model, check registers.
    task automatic cyc(input logic [9:0] req, input bit n, input bit inh, input bit ov,
                       input bit ex, input bit res, input bit goj, input bit rs);
        bit any, exp_rn, acc;
        int sel;
        @(negedge clock);
        rupt_req = req; nisq = n; inhint = inh; ovnhrp = ov; ext = ex;
        resume = res; gojam = goj; rst_n = rs;
        #1;
        any = 1'b0; sel = -1;
        for (int i = 0; i < 10; i++) if (m_pend[i]) begin any = 1'b1; if (sel < 0) sel = i; end
        exp_rn = !(any && !m_iip && !inh && !ov && !ex);
        if (m_valid) chk("ruptor_n", {31'b0, ruptor_n}, {31'b0, exp_rn});
        if (!rs || goj) begin
            for (int i = 0; i < 10; i++) m_pend[i] = 1'b0;
            m_iip = 1'b0; m_krpt = 1'b0; m_idx = 0; m_valid = 1'b1;
        end else begin
            acc = n && !exp_rn;
            m_krpt = acc;
            if (acc) begin
                m_pend[sel] = 1'b0;
                m_iip = 1'b1;
                m_idx = sel + 1;
            end else if (res && m_iip) begin
                m_iip = 1'b0;
                m_idx = 0;
            end
            for (int i = 0; i < 10; i++) if (req[i]) m_pend[i] = 1'b1;
        end
        @(posedge clock);
        #1;
        if (m_valid) begin
            chk("krpt", {31'b0, krpt}, {31'b0, m_krpt});
            chk("iip", {31'b0, iip}, {31'b0, m_iip});
            chk("rupt_index", {28'b0, rupt_index}, m_idx);
            chk("rupt_addr", {20'b0, rupt_addr}, 12'o4000 + 4 * m_idx);
            chk("pending", {22'b0, pending}, {22'b0, model_pending()});
        end
    endtask

    task automatic idle();
        cyc('0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_resume();
        cyc('0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        logic [9:0] r;
        m_valid = 1'b0;

        // Reset held three clocks
        repeat (3) cyc('0, 0, 0, 0, 0, 0, 0, 0);
        chk("pin_reset_addr", {20'b0, rupt_addr}, 32'o4000);
        chk("pin_reset_index", {28'b0, rupt_index}, 0);
        idle();
        chk("pin_reset_ruptor", {31'b0, ruptor_n}, 1);

        // Single source KEYRUPT1
        cyc(10'h010, 0, 0, 0, 0, 0, 0, 1);
        chk("pin_single_ruptor", {31'b0, ruptor_n}, 0);
        idle();
        cyc('0, 1, 0, 0, 0, 0, 0, 1);
        chk("pin_single_idx", {28'b0, rupt_index}, 5);
        chk("pin_single_addr", {20'b0, rupt_addr}, 32'o4024);
        chk("pin_single_krpt", {31'b0, krpt}, 1);
        chk("pin_single_pend", {22'b0, pending}, 0);
        idle();
        chk("pin_single_krpt_drop", {31'b0, krpt}, 0);
        do_resume();
        chk("pin_resume_addr", {20'b0, rupt_addr}, 32'o4000);

        // Priority and queueing
        cyc(10'h084, 0, 0, 0, 0, 0, 0, 1);
        cyc('0, 1, 0, 0, 0, 0, 0, 1);
        chk("pin_prio_idx", {28'b0, rupt_index}, 3);
        chk("pin_prio_addr", {20'b0, rupt_addr}, 32'o4014);
        chk("pin_prio_pend", {22'b0, pending}, 32'h080);
        cyc('0, 1, 0, 0, 0, 0, 0, 1);
        do_resume();
        cyc('0, 1, 0, 0, 0, 0, 0, 1);
        chk("pin_queue_idx", {28'b0, rupt_index}, 8);
        chk("pin_queue_addr", {20'b0, rupt_addr}, 32'o4040);
        do_resume();

        // Each inhibit blocks acceptance
        cyc(10'h001, 0, 0, 0, 0, 0, 0, 1);
        cyc('0, 1, 1, 0, 0, 0, 0, 1);
        cyc('0, 1, 0, 1, 0, 0, 0, 1);
        cyc('0, 1, 0, 0, 1, 0, 0, 1);
        chk("pin_inhibit_iip", {31'b0, iip}, 0);
        cyc('0, 1, 0, 0, 0, 0, 0, 1);
        chk("pin_inhibit_idx", {28'b0, rupt_index}, 1);
        chk("pin_inhibit_addr", {20'b0, rupt_addr}, 32'o4004);
        do_resume();

        // Collision on source 0
        cyc(10'h001, 0, 0, 0, 0, 0, 0, 1);
        cyc(10'h001, 1, 0, 0, 0, 0, 0, 1);
        chk("pin_collide_krpt", {31'b0, krpt}, 1);
        chk("pin_collide_pend0", {31'b0, pending[0]}, 1);

        // GOJAM while interrupt in progress
        cyc(10'h202, 0, 0, 0, 0, 0, 0, 1);
        cyc('0, 0, 0, 0, 0, 0, 1, 1);
        chk("pin_gojam_pend", {22'b0, pending}, 0);
        chk("pin_gojam_iip", {31'b0, iip}, 0);
        idle();

        // Reset on an acceptance edge
        cyc(10'h008, 0, 0, 0, 0, 0, 0, 1);
        cyc('0, 1, 0, 0, 0, 0, 0, 0);
        chk("pin_rst_accept_krpt", {31'b0, krpt}, 0);
        chk("pin_rst_accept_pend", {22'b0, pending}, 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            r = 10'($urandom) & 10'($urandom) & 10'($urandom) & 10'($urandom);
            cyc(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 199) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rupt_priority.md
# rupt_priority

Interrupt request latch and priority encoder for the AGC control section. It captures one-clock request pulses from the ten interrupt sources and resolves the highest-priority pending source. When interrupts are allowed, it drives `ruptor_n` low so `sq_register` substitutes a RUPT sequence at the next NISQ. On acceptance it pulses `krpt`, presents the vector index and address, and holds interrupt-in-progress until RESUME or GOJAM.

## Interface
Parameters:
- `RUPT_BASE`, default 12'o4000: vector base address; GOJAM start address.
- `RUPT_STRIDE`, default 4: words per vector slot.

Ports:
- `clock` in 1: system clock, same net as timer/scaler.
- `rst_n` in 1: reset, synchronous, active-low.
- `rupt_req` in 10: request pulses, one clock wide. Priority order: bit0 T6RUPT (highest), bit1 T5, bit2 T3, bit3 T4, bit4 KEYRUPT1, bit5 KEYRUPT2, bit6 UPRUPT, bit7 DOWNRUPT, bit8 RADARUPT, bit9 HANDRUPT (lowest).
- `gojam` in 1: restart; clears all state like reset.
- `nisq` in 1: next-instruction strobe from sequencer; the acceptance point.
- `inhint` in 1: software interrupt inhibit (INHINT/RELINT state).
- `ovnhrp` in 1: overflow-in-A inhibit.
- `ext` in 1: EXTEND pending; inhibits interrupts.
- `resume` in 1: one-clock pulse at RESUME; ends the interrupt.
- `ruptor_n` out 1: low = interrupt will be taken at next `nisq`.
- `krpt` out 1: one-clock acknowledge pulse for the accepted source.
- `iip` out 1: interrupt in progress.
- `rupt_index` out 4: accepted source, 1..10 (bit number + 1); 0 = none.
- `rupt_addr` out 12: `RUPT_BASE + RUPT_STRIDE*rupt_index`.
- `pending` out 10: request latches, for monitor.

## Operation
- Pending latches:
  - `pending[i]` sets on any clock edge with `rupt_req[i]`=1.
  - It clears only on acceptance of source i, or on reset/gojam.
  - A pulse on an already-pending source is absorbed; no count is kept.
- Priority: `sel` = lowest-numbered set bit of `pending`; `any` = |pending.
- `ruptor_n` = !(any & !iip & !inhint & !ovnhrp & !ext). It is a combinational decode of registered state and inputs, with no extra register.
- Acceptance happens on a clock edge with `nisq`=1 and `ruptor_n`=0. At that edge:
  - `pending[sel]` clears.
  - `iip` sets.
  - `rupt_index` loads sel+1.
  - `krpt` is 1 for the following cycle only.
- Collision rule: if `rupt_req[sel]` arrives on the acceptance edge, set wins and the bit stays pending. The new event must not be lost.
- `nisq` with `ruptor_n`=1 has no effect.
- `resume` clears `iip`. `rupt_index` returns to 0 on the same edge; `rupt_addr` follows to RUPT_BASE.
- `resume` with `iip`=0 has no effect.
- `resume` and acceptance cannot coincide, because acceptance requires `iip`=0.
- While `iip`=1, requests keep latching but none is accepted. Nested interrupts are not permitted.
- Reset (`rst_n`=0) or `gojam`=1 at a clock edge overrides all other inputs, including a mid-acceptance edge. Result: `pending`=0, `iip`=0, `rupt_index`=0, `krpt`=0.
- State summary: IDLE (iip=0) → ACCEPT edge → INRUPT (iip=1) → resume → IDLE.

## Timing
- Reset values:
  - `ruptor_n`=1, `krpt`=0, `iip`=0.
  - `rupt_index`=0, `rupt_addr`=12'o4000, `pending`=0.
- Request at edge N → `pending` visible after N. `ruptor_n` falls in the same cycle if not inhibited. Request-to-ruptor latency is 1 clock.
- `nisq` sampled at edge M with `ruptor_n`=0 → during cycle M+1:
  - `krpt`=1, `iip`=1.
  - `rupt_index`/`rupt_addr` valid; `ruptor_n`=1.
  - `krpt` is 0 from M+2.
- Inhibit inputs act combinationally on `ruptor_n`. Raising `inhint` in the cycle of `nisq` blocks acceptance.
- `rupt_index`/`rupt_addr` stay stable from M+1 until the `resume` edge.

## Test plan
- Reset then idle: `rst_n`=0 for 3 clocks → all outputs at reset values; `rupt_addr`=12'o4000.
- Single source: pulse `rupt_req[4]` (KEYRUPT1), then `nisq` 2 clocks later → `ruptor_n` low 1 clock after the pulse. Next cycle shows `krpt` 1 cycle, `rupt_index`=5, `rupt_addr`=12'o4024, `iip`=1, `pending`=0.
- Priority and queueing: pulse bits 7 and 2 together, then `nisq` → index 3 (12'o4014) first, bit 7 still pending, `ruptor_n`=1 while `iip`. Then `resume`, then `nisq` → index 8 (12'o4040).
- Inhibits: pending bit0 with `inhint`=1 and `nisq` pulsed → no acceptance, `ruptor_n`=1. Repeat with `ovnhrp`, then `ext`. Drop all three, pulse `nisq` → index 1 (12'o4004).
- Collision: `rupt_req[0]` pulsed on the acceptance edge of source 0 → `krpt` fires, `pending[0]` remains 1.
- Restart mid-operation: `iip`=1 with bits 1 and 9 pending, assert `gojam` one clock → `pending`=0, `iip`=0, `rupt_index`=0, `ruptor_n`=1. Repeat with `rst_n`=0 on an acceptance edge → no `krpt`.
